// File: rtl/seq_shift_unit_pkg.sv
// Shared encodings for the multi-cycle shift / load-upper unit.
package seq_shift_unit_pkg;

    // Operation select as driven by the core's control unit.
    typedef enum logic [1:0] {
        OP_LUI = 2'b00,
        OP_SLL = 2'b01,
        OP_SRL = 2'b10,
        OP_SRA = 2'b11
    } op_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Start/done handshake and operand bus between the control unit and the shift unit.
interface seq_shift_unit_if #(
    parameter int N = 32
) ();
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] res;

    modport master (
        output start, op, A, B,
        input  ready, busy, done, res
    );

    modport slave (
        input  start, op, A, B,
        output ready, busy, done, res
    );
endinterface

// File: rtl/seq_shift_unit_shift_step.sv
// One iteration of the shifter: moves data by 0..STEP bits in the selected direction.
// For right shifts the vacated high bits take 'fill', which only matters for SRA.
module shift_step
    import seq_shift_unit_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = 4,
    localparam int KW  = $clog2(STEP + 1)
) (
    input  logic [N-1:0]  data,
    input  logic [KW-1:0] amt,
    input  op_t           op,
    input  logic          fill,
    output logic [N-1:0]  dout
);
    logic [N-1:0] fill_mask;

    // Ones in exactly the bit positions vacated by a right shift of 'amt'.
    assign fill_mask = fill ? ~({N{1'b1}} >> amt) : '0;

    // Per-bit mux between the shifted-in neighbour and the fill value.
    always_comb begin
        dout = data;
        case (op)
            OP_SLL:  dout = data << amt;
            OP_SRL:  dout = data >> amt;
            OP_SRA:  dout = (data >> amt) | fill_mask;
            default: dout = data;
        endcase
    end
endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift and load-upper unit. Shifts STEP bits per cycle until the
// latched amount is exhausted; LUI and zero-amount shifts complete immediately.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | ready; accepts start, latches operand/op/amount
// S_SHIFT | shifting work register by min(STEP, rem) each cycle
// S_DONE  | done pulse; res already holds the result
module seq_shift_unit
    import seq_shift_unit_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_shift_unit_if.slave bus
);
    localparam int SHW = $clog2(N);
    localparam int KW  = $clog2(STEP + 1);

    state_t         state;
    state_t         state_nx;
    op_t            op_q;
    op_t            op_in;
    logic           fill_q;
    logic           accept;
    logic [SHW-1:0] rem;
    logic [SHW-1:0] rem_nx;
    logic [SHW-1:0] amt_in;
    logic [31:0]    rem_ext;
    logic [KW-1:0]  k;
    logic [N-1:0]   work;
    logic [N-1:0]   work_nx;
    logic [N-1:0]   load_val;
    logic [N-1:0]   shifted;
    logic [N-1:0]   res_q;
    logic           unused_b;

    assign op_in  = op_t'(bus.op);
    assign amt_in = bus.B[SHW-1:0];

    // Upper amount bits are deliberately ignored; shifts are modulo N.
    assign unused_b = ^bus.B[N-1:SHW];

    // LUI is finished at accept time, so the work register takes its final value directly.
    assign load_val = (op_in == OP_LUI) ? {bus.A[N/2-1:0], {(N/2){1'b0}}} : bus.A;

    // Bits moved this cycle: min(STEP, rem). Compared at 32 bits so STEP == N is safe.
    assign rem_ext = 32'(rem);
    assign k       = (rem_ext >= 32'(STEP)) ? KW'(STEP) : KW'(rem);

    shift_step #(
        .N    (N),
        .STEP (STEP)
    ) u_step (
        .data (work),
        .amt  (k),
        .op   (op_q),
        .fill (fill_q),
        .dout (shifted)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath-next decode.
    always_comb begin
        state_nx = state;
        work_nx  = work;
        rem_nx   = rem;
        accept   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    work_nx = load_val;
                    rem_nx  = amt_in;
                    if (op_in == OP_LUI || amt_in == '0) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_nx = shifted;
                rem_nx  = rem - SHW'(k);
                if (rem_nx == '0) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Work/rem/op registers, and the result captured on the edge entering S_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= '0;
            rem    <= '0;
            op_q   <= OP_LUI;
            fill_q <= 1'b0;
            res_q  <= '0;
        end else begin
            work <= work_nx;
            rem  <= rem_nx;
            if (accept) begin
                op_q   <= op_in;
                fill_q <= bus.A[N-1];
            end
            if (state_nx == S_DONE && state != S_DONE) begin
                res_q <= work_nx;
            end
        end
    end

    assign bus.ready = (state == S_IDLE);
    assign bus.busy  = (state == S_SHIFT) || (state == S_DONE);
    assign bus.done  = (state == S_DONE);
    assign bus.res   = res_q;
endmodule
